// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: request/acknowledge and sequenced-reset bundle between
// the reset sequencer (master) and the blocks it brings out of reset (slave).
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                          sw_rst_req;
    logic [NUM_STAGES-1:0]         stage_ack;
    logic [NUM_STAGES-1:0]         rst_out;
    logic                          seq_busy;
    logic                          seq_done;
    logic                          timeout_err;
    logic [$clog2(NUM_STAGES)-1:0] cur_stage;

    modport master (
        input  sw_rst_req, stage_ack,
        output rst_out, seq_busy, seq_done, timeout_err, cur_stage
    );

    modport slave (
        output sw_rst_req, stage_ack,
        input  rst_out, seq_busy, seq_done, timeout_err, cur_stage
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: stretches reset, then releases stages in ascending order.
// Define RST_SEQ_ACK_EN to wait for each stage's acknowledge (with timeout).
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 8,
    parameter int ACK_TIMEOUT    = 255
) (
    input logic clk,
    input logic reset,
    reset_sequencer_if.master bus
);
    localparam int SW    = $clog2(NUM_STAGES);
    localparam int MAX_A = STRETCH_CYCLES > STAGE_GAP ? STRETCH_CYCLES : STAGE_GAP;
    localparam int MAXC  = MAX_A > ACK_TIMEOUT ? MAX_A : ACK_TIMEOUT;
    localparam int CW    = $clog2(MAXC + 1);
`ifdef RST_SEQ_ACK_EN
    typedef enum logic [1:0] {ASSERT, WAIT_ACK, GAP, DONE} state_t;
    localparam state_t RELEASED = WAIT_ACK;
`else
    typedef enum logic [1:0] {ASSERT, GAP, DONE} state_t;
    localparam state_t RELEASED = GAP;
    logic unused_ack;
    assign unused_ack = ^bus.stage_ack;
`endif
    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [SW-1:0]         stage_nx;
    logic [NUM_STAGES-1:0] rst_nx;
    logic                  terr_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stage_nx = bus.cur_stage;
        rst_nx   = bus.rst_out;
        terr_nx  = bus.timeout_err;
        if (bus.sw_rst_req) begin
            state_nx = ASSERT;
            cnt_nx   = '0;
            stage_nx = '0;
            rst_nx   = '1;
            terr_nx  = 1'b0;
        end else begin
            case (state)
                ASSERT: begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == CW'(STRETCH_CYCLES - 1)) begin
                        cnt_nx    = '0;
                        stage_nx  = '0;
                        rst_nx[0] = 1'b0;
                        state_nx  = RELEASED;
                    end
                end
`ifdef RST_SEQ_ACK_EN
                WAIT_ACK: begin
                    cnt_nx = cnt + CW'(1);
                    if (bus.stage_ack[bus.cur_stage] || cnt == CW'(ACK_TIMEOUT - 1)) begin
                        terr_nx  = bus.timeout_err | ~bus.stage_ack[bus.cur_stage];
                        cnt_nx   = '0;
                        state_nx = GAP;
                    end
                end
`endif
                GAP: begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == CW'(STAGE_GAP - 1)) begin
                        cnt_nx = '0;
                        if (bus.cur_stage == SW'(NUM_STAGES - 1)) begin
                            state_nx = DONE;
                        end else begin
                            stage_nx         = bus.cur_stage + SW'(1);
                            rst_nx[stage_nx] = 1'b0;
                            state_nx         = RELEASED;
                        end
                    end
                end
                default: rst_nx = '0;
            endcase
        end
    end

    // Outputs are registered from the next-state values so they track state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ASSERT;
            cnt             <= '0;
            bus.rst_out     <= '1;
            bus.cur_stage   <= '0;
            bus.seq_busy    <= 1'b1;
            bus.seq_done    <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            bus.rst_out     <= rst_nx;
            bus.cur_stage   <= stage_nx;
            bus.seq_busy    <= state_nx != DONE;
            bus.seq_done    <= state_nx == DONE;
            bus.timeout_err <= terr_nx;
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed edge-numbered vectors for the reset sequencer
module tb_reset_sequencer;
  typedef struct {
    int         e;
    logic       rs;
    logic       sw;
    logic [3:0] ack;
    logic [3:0] rst;
    logic [1:0] stg;
    logic       busy;
    logic       done;
    logic       terr;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   edge_n = -2;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tab[$];
  reset_sequencer_if #(.NUM_STAGES(4)) bus ();
  reset_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic add(input int e, input logic rs, input logic sw, input logic [3:0] ack,
                     input logic [3:0] rst, input logic [1:0] stg, input logic busy,
                     input logic done, input logic terr);
    vec_t v;
    v.e = e; v.rs = rs; v.sw = sw; v.ack = ack; v.rst = rst;
    v.stg = stg; v.busy = busy; v.done = done; v.terr = terr;
    tab.push_back(v);
  endtask
  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask
  task automatic chk(input int e, input logic [8:0] exp);
    logic [8:0] got;
    got = {bus.rst_out, bus.cur_stage, bus.seq_busy, bus.seq_done, bus.timeout_err};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL edge%0d {rst_out,cur_stage,busy,done,terr}: got %b expected %b", e, got, exp);
    end
  endtask
  initial begin
    bus.sw_rst_req = 1'b0;
    bus.stage_ack  = '0;
    add(-1, 1, 0, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add( 0, 1, 0, 4'b0000, 4'b1111, 0, 1, 0, 0);
`ifndef RST_SEQ_ACK_EN
    add(  1, 0, 0, 4'b1111, 4'b1111, 0, 1, 0, 0);
    add( 15, 0, 0, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add( 16, 0, 0, 4'b0000, 4'b1110, 0, 1, 0, 0);
    add( 17, 0, 0, 4'b1111, 4'b1110, 0, 1, 0, 0);
    add( 23, 0, 0, 4'b0000, 4'b1110, 0, 1, 0, 0);
    add( 24, 0, 0, 4'b0000, 4'b1100, 1, 1, 0, 0);
    add( 31, 0, 0, 4'b0000, 4'b1100, 1, 1, 0, 0);
    add( 32, 0, 0, 4'b0000, 4'b1000, 2, 1, 0, 0);
    add( 40, 0, 0, 4'b0000, 4'b0000, 3, 1, 0, 0);
    add( 47, 0, 0, 4'b0000, 4'b0000, 3, 1, 0, 0);
    add( 48, 0, 0, 4'b0000, 4'b0000, 3, 0, 1, 0);
    add( 60, 0, 0, 4'b1111, 4'b0000, 3, 0, 1, 0);
    add( 61, 0, 1, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add( 76, 0, 0, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add( 77, 0, 0, 4'b0000, 4'b1110, 0, 1, 0, 0);
    add( 85, 0, 0, 4'b0000, 4'b1100, 1, 1, 0, 0);
    add( 93, 0, 0, 4'b0000, 4'b1000, 2, 1, 0, 0);
    add(101, 0, 0, 4'b0000, 4'b0000, 3, 1, 0, 0);
    add(109, 0, 0, 4'b0000, 4'b0000, 3, 0, 1, 0);
    add(113, 0, 1, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add(129, 0, 0, 4'b0000, 4'b1110, 0, 1, 0, 0);
    add(137, 0, 0, 4'b0000, 4'b1100, 1, 1, 0, 0);
    add(140, 0, 1, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add(156, 0, 0, 4'b0000, 4'b1110, 0, 1, 0, 0);
    add(164, 0, 0, 4'b0000, 4'b1100, 1, 1, 0, 0);
    add(172, 0, 0, 4'b0000, 4'b1000, 2, 1, 0, 0);
    add(180, 0, 0, 4'b0000, 4'b0000, 3, 1, 0, 0);
    add(188, 0, 0, 4'b0000, 4'b0000, 3, 0, 1, 0);
    add(190, 1, 1, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add(191, 1, 1, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add(192, 1, 1, 4'b1111, 4'b1111, 0, 1, 0, 0);
    add(207, 0, 0, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add(208, 0, 0, 4'b0000, 4'b1110, 0, 1, 0, 0);
    add(216, 0, 1, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add(231, 0, 0, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add(232, 0, 0, 4'b0000, 4'b1110, 0, 1, 0, 0);
    add(240, 0, 0, 4'b0000, 4'b1100, 1, 1, 0, 0);
`else
    add( 15, 0, 0, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add( 16, 0, 0, 4'b0001, 4'b1110, 0, 1, 0, 0);
    add( 17, 0, 0, 4'b0001, 4'b1110, 0, 1, 0, 0);
    add( 25, 0, 0, 4'b0000, 4'b1100, 1, 1, 0, 0);
    add( 26, 0, 0, 4'b1101, 4'b1100, 1, 1, 0, 0);
    add( 30, 0, 0, 4'b0010, 4'b1100, 1, 1, 0, 0);
    add( 37, 0, 0, 4'b0000, 4'b1100, 1, 1, 0, 0);
    add( 38, 0, 0, 4'b0000, 4'b1000, 2, 1, 0, 0);
    add(292, 0, 0, 4'b1011, 4'b1000, 2, 1, 0, 0);
    add(293, 0, 0, 4'b0000, 4'b1000, 2, 1, 0, 1);
    add(300, 0, 0, 4'b0000, 4'b1000, 2, 1, 0, 1);
    add(301, 0, 0, 4'b0000, 4'b0000, 3, 1, 0, 1);
    add(302, 0, 0, 4'b1000, 4'b0000, 3, 1, 0, 1);
    add(309, 0, 0, 4'b0000, 4'b0000, 3, 1, 0, 1);
    add(310, 0, 0, 4'b0000, 4'b0000, 3, 0, 1, 1);
    add(320, 0, 1, 4'b0000, 4'b1111, 0, 1, 0, 0);
    add(336, 0, 0, 4'b0000, 4'b1110, 0, 1, 0, 0);
`endif
    foreach (tab[i]) begin
      while (edge_n < tab[i].e - 1) tick();
      reset          = tab[i].rs;
      bus.sw_rst_req = tab[i].sw;
      bus.stage_ack  = tab[i].ack;
      tick();
      reset          = 1'b0;
      bus.sw_rst_req = 1'b0;
      bus.stage_ack  = '0;
      chk(tab[i].e, {tab[i].rst, tab[i].stg, tab[i].busy, tab[i].done, tab[i].terr});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk(edge_n, 9'b1111_00_1_0_0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of sequenced reset outputs (2..16).
REQ-002 SHALL have parameter STRETCH_CYCLES, default 16, minimum all-stages-asserted hold time in clocks (>=1).
REQ-003 SHALL have parameter STAGE_GAP, default 8, clocks between consecutive stage releases (>=1).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 255, maximum clocks to wait for a stage acknowledge (>=1).
REQ-005 SHALL have port clk  input  1  clock; all logic is on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port sw_rst_req  input  1  single-cycle software reset request, sampled each edge.
REQ-008 SHALL have port stage_ack  input  NUM_STAGES  per-stage "out of reset" acknowledge, level.
REQ-009 SHALL have port rst_out  output  NUM_STAGES  registered active-high reset per stage; bit 0 released first.
REQ-010 SHALL have port seq_busy  output  1  high while any rst_out bit is asserted or a gap is pending.
REQ-011 SHALL have port seq_done  output  1  high only in DONE state.
REQ-012 SHALL have port timeout_err  output  1  sticky ack-timeout flag.
REQ-013 SHALL have port cur_stage  output  $clog2(NUM_STAGES)  index of stage currently being released.

Function
REQ-014 SHALL implement states ASSERT, WAIT_ACK, GAP, DONE; all outputs registered.
REQ-015 ASSERT: rst_out all ones; counter increments each edge; on the STRETCH_CYCLES-th edge in ASSERT, clear rst_out[0], set cur_stage=0, go to WAIT_ACK (macro on) or GAP (macro off).
REQ-016 WAIT_ACK: on the edge stage_ack[cur_stage] is sampled high, go to GAP with counter cleared.
REQ-017 WAIT_ACK: if ACK_TIMEOUT edges elapse after release without ack, set timeout_err and go to GAP as if acked.
REQ-018 GAP: after STAGE_GAP edges, if cur_stage==NUM_STAGES-1 go to DONE, else increment cur_stage, clear rst_out[cur_stage+1] on that same edge, go to WAIT_ACK/GAP.
REQ-019 DONE: rst_out all zeros, seq_done=1, seq_busy=0; held until sw_rst_req or reset.
REQ-020 sw_rst_req sampled high in any state SHALL on that edge set rst_out all ones, clear counter, cur_stage and timeout_err, seq_done=0, enter ASSERT (restart mid-sequence included).
REQ-021 sw_rst_req coinciding with a state transition edge SHALL take priority over the transition.
REQ-022 Released rst_out bits SHALL never re-assert except via reset or sw_rst_req; stages release strictly in ascending order.
REQ-023 stage_ack bits other than cur_stage, and any ack outside WAIT_ACK, SHALL be ignored.
REQ-024 Counters SHALL be sized to max(STRETCH_CYCLES, STAGE_GAP, ACK_TIMEOUT) and never wrap within a state.

Reset
REQ-025 reset high SHALL on the next edge force: state ASSERT, rst_out all ones, counter 0, cur_stage 0, seq_busy 1, seq_done 0, timeout_err 0.
REQ-026 reset SHALL override sw_rst_req and stage_ack; stretch counting begins on the first edge with reset low.

Configuration
REQ-027 Macro RST_SEQ_ACK_EN defined: WAIT_ACK state, stage_ack handshake and timeout_err logic SHALL be compiled in.
REQ-028 Macro RST_SEQ_ACK_EN undefined: WAIT_ACK absent, release goes directly to GAP, stage_ack ignored, timeout_err tied 0.

Verification
REQ-029 Defaults, macro off, reset low at edge 0: rst_out[0..3] fall at edges 16/24/32/40; seq_done=1 and seq_busy=0 at edge 48.
REQ-030 Macro on, stage_ack[1] raised 5 edges after rst_out[1] falls: rst_out[2] falls 8 edges after the ack edge; timeout_err stays 0.
REQ-031 Macro on, stage_ack[2] held low: timeout_err=1 at edge 255 after rst_out[2] falls; rst_out[3] falls 8 edges later; sequence completes.
REQ-032 sw_rst_req pulsed during GAP after stage 1 released: next edge rst_out=4'b1111, cur_stage=0, timeout_err=0; full sequence replays with REQ-029 timing.
REQ-033 reset asserted in DONE for 3 cycles with sw_rst_req also high: rst_out=4'b1111 after first edge; sequence restarts from reset deassertion, no double restart.
